// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Single-outstanding instruction fetch unit. It issues one ROM read, captures
// the returned word one cycle later, and presents it to the consumer with a
// valid/ready handshake. A new read is only issued once the held word has been
// taken (REQ -> WAIT -> HOLD -> REQ), so peak throughput is one word every
// 3 cycles. The latency from a read strobe to valid is 2 cycles.
//
// A branch redirects fetch_pc in any running state. It discards any word that
// is in flight (WAIT) or held (HOLD).
//
// Optional feature, selected by the macro FETCH_HALT_EN:
//   When defined, a held word equal to 20'hFFFFF (HALT) is presented like any
//   other word. Its transfer parks the unit in HALTED, and only reset leaves
//   that state. When undefined, HALTED does not exist and halted is tied to 0.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   pc_write       in   fetch enable (0 stalls issue of new reads)
//   branch         in   redirect request, single cycle
//   branch_target  in   [19:0] redirect address
//   rom_load       out  ROM read strobe
//   rom_address    out  [19:0] ROM read address (= fetch_pc)
//   rom_data       in   [19:0] ROM data, valid the cycle after rom_load
//   instruction    out  [19:0] held instruction word
//   pc             out  [19:0] address of the held word
//   instr_valid    out  instruction/pc valid
//   instr_ready    in   consumer accept
//   halted         out  fetch stopped by a HALT word
// -----------------------------------------------------------------------------
module instruction_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch,
    input  logic [19:0] branch_target,
    output logic        rom_load,
    output logic [19:0] rom_address,
    input  logic [19:0] rom_data,
    output logic [19:0] instruction,
    output logic [19:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted
);

    localparam int AW = 20;

`ifdef FETCH_HALT_EN
    localparam logic [AW-1:0] HALT_WORD = '1;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALTED} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    // Word held for the consumer, paired with the address it came from.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [AW-1:0] word;
    } fetch_word_t;

    state_t      state, state_next;
    logic [AW-1:0] fetch_pc, fetch_pc_next;
    fetch_word_t held, held_next;
    logic        valid_next;
    logic        transfer;
    logic        running;

`ifdef FETCH_HALT_EN
    logic halted_q, halted_next;
    assign halted  = halted_q;
    assign running = (state != S_HALTED);
`else
    assign halted  = 1'b0;
    assign running = 1'b1;
`endif

    assign rom_address = fetch_pc;
    assign instruction = held.word;
    assign pc          = held.addr;
    assign transfer    = instr_valid & instr_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            fetch_pc    <= '0;
            held        <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q    <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            held        <= held_next;
            instr_valid <= valid_next;
`ifdef FETCH_HALT_EN
            halted_q    <= halted_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        held_next     = held;
        valid_next    = instr_valid;
        rom_load      = 1'b0;
`ifdef FETCH_HALT_EN
        halted_next   = halted_q;
`endif

        unique case (state)
            S_REQ: begin
                // The strobe is masked by reset so no read is issued while
                // the unit is being cleared.
                if (pc_write && !branch && !reset) begin
                    rom_load   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // rom_data returns this cycle; pc_write does not matter here.
                held_next     = '{addr: fetch_pc, word: rom_data};
                valid_next    = 1'b1;
                fetch_pc_next = fetch_pc + AW'(1);
                state_next    = S_HOLD;
            end
            S_HOLD: begin
                if (transfer) begin
                    valid_next = 1'b0;
`ifdef FETCH_HALT_EN
                    if (held.word == HALT_WORD) begin
                        state_next  = S_HALTED;
                        halted_next = 1'b1;
                    end else begin
                        state_next  = S_REQ;
                    end
`else
                    state_next = S_REQ;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            S_HALTED: begin
                valid_next = 1'b0;
            end
`endif
            default: begin
                state_next = S_REQ;
                valid_next = 1'b0;
            end
        endcase

        // A branch overrides every per-state decision above. The capture in
        // WAIT and any held word in HOLD are dropped, even when a transfer
        // coincides with the branch.
        if (branch && running) begin
            fetch_pc_next = branch_target;
            held_next     = held;
            valid_next    = 1'b0;
            state_next    = S_REQ;
            rom_load      = 1'b0;
`ifdef FETCH_HALT_EN
            halted_next   = halted_q;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. A ROM responder returns
// rom_fn(address) one cycle after each read strobe and random junk otherwise.
// The scenario tasks check the directed behaviours. A randomized run checks
// program order against a simple model:
//   - each read goes to the next address due for delivery;
//   - delivered words are consecutive and restart at a branch target;
//   - a held word stays stable until it is taken.
// Behaviour under FETCH_HALT_EN follows the same macro.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write = 1'b0;
    logic        branch = 1'b0;
    logic [19:0] branch_target = '0;
    logic        rom_load;
    logic [19:0] rom_address;
    logic [19:0] rom_data = '0;
    logic [19:0] instruction;
    logic [19:0] pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;

    int errors = 0;
    int checks = 0;

    instruction_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .pc_write     (pc_write),
        .branch       (branch),
        .branch_target(branch_target),
        .rom_load     (rom_load),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .instruction  (instruction),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // ROM contents. Only address 3 holds 20'hFFFFF.
    function automatic logic [19:0] rom_fn(input logic [19:0] a);
        logic [19:0] v;
        case (a)
            20'h00000: v = 20'h11111;
            20'h00001: v = 20'h22222;
            20'h00002: v = 20'h33333;
            20'h00003: v = 20'hFFFFF;
            default: begin
                v = a ^ 20'h5A5A5;
                if (v == 20'hFFFFF) v = 20'h00000;
            end
        endcase
        return v;
    endfunction

    always @(posedge clk)
        rom_data <= rom_load ? rom_fn(rom_address) : 20'($urandom);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; branch = 1'b0; pc_write = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; pc_write = 1'b1; branch = 1'b1; branch_target = 20'h12345;
        instr_ready = 1'b1;
        #1;
        tick(); #1;
        checks++;
        if (rom_load !== 1'b0) begin errors++; $display("FAIL reset_rom_load got=%b exp=0", rom_load); end
        tick();
        checks++;
        if ({instr_valid, halted, pc, instruction, rom_address} !== {2'b00, 60'h0}) begin
            errors++;
            $display("FAIL reset_state got v=%b h=%b pc=%h ins=%h addr=%h exp all zero",
                     instr_valid, halted, pc, instruction, rom_address);
        end
        branch = 1'b0; pc_write = 1'b0; reset = 1'b0;
    endtask

    // Back-to-back stream: latency, cadence and contents.
    task automatic test_stream();
        int t_load;
        int tv[$];
        logic [19:0] pcs[$];
        logic [19:0] ins[$];
        logic [19:0] first_addr;
        t_load = -1;
        first_addr = 'x;
        do_reset();
        pc_write = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (rom_load && t_load < 0) begin t_load = c; first_addr = rom_address; end
            if (instr_valid) begin tv.push_back(c); pcs.push_back(pc); ins.push_back(instruction); end
            tick();
        end
        checks++;
        if (tv.size() < 3 || t_load < 0) begin
            errors++;
            $display("FAIL stream_count got words=%0d load_seen=%0d exp>=3,1", tv.size(), t_load >= 0);
        end else begin
            checks++;
            if (first_addr !== 20'h0) begin errors++; $display("FAIL stream_first_addr got=%h exp=00000", first_addr); end
            checks++;
            if (tv[0] - t_load != 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", tv[0] - t_load); end
            checks++;
            if (tv[1] - tv[0] != 3 || tv[2] - tv[1] != 3) begin
                errors++; $display("FAIL stream_cadence got=%0d,%0d exp=3,3", tv[1] - tv[0], tv[2] - tv[1]);
            end
            checks++;
            if ({ins[0], ins[1], ins[2]} !== {20'h11111, 20'h22222, 20'h33333}) begin
                errors++; $display("FAIL stream_words got=%h %h %h exp=11111 22222 33333", ins[0], ins[1], ins[2]);
            end
            checks++;
            if ({pcs[0], pcs[1], pcs[2]} !== {20'h0, 20'h1, 20'h2}) begin
                errors++; $display("FAIL stream_pcs got=%h %h %h exp=0 1 2", pcs[0], pcs[1], pcs[2]);
            end
        end
    endtask

    // Consumer stalls with 22222 held.
    task automatic test_backpressure();
        bit found;
        found = 1'b0;
        do_reset();
        pc_write = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            #1;
            if (instr_valid && pc == 20'h1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL bp_reach got=timeout exp=pc 00001 valid"); return; end
        instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({instr_valid, rom_load, pc, instruction} !== {2'b10, 20'h1, 20'h22222}) begin
                errors++;
                $display("FAIL bp_stable cyc=%0d got v=%b ld=%b pc=%h ins=%h exp v=1 ld=0 pc=00001 ins=22222",
                         c, instr_valid, rom_load, pc, instruction);
            end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got=%b exp=1", instr_valid); end
        tick(); #1;
        checks++;
        if ({instr_valid, rom_load, rom_address} !== {2'b01, 20'h2}) begin
            errors++;
            $display("FAIL bp_release got v=%b ld=%b addr=%h exp v=0 ld=1 addr=00002", instr_valid, rom_load, rom_address);
        end
    endtask

    // Branch while a read is in flight.
    task automatic test_branch_wait();
        bit found;
        bit leaked;
        found = 1'b0; leaked = 1'b0;
        do_reset();
        pc_write = 1'b1; instr_ready = 1'b1;
        tick();                       // read of address 0 issued, now in WAIT
        branch = 1'b1; branch_target = 20'h00040;
        #1;
        checks++;
        if (rom_load !== 1'b0) begin errors++; $display("FAIL bw_load_on_branch got=%b exp=0", rom_load); end
        tick();
        branch = 1'b0;
        #1;
        checks++;
        if ({instr_valid, rom_load, rom_address} !== {2'b01, 20'h00040}) begin
            errors++;
            $display("FAIL bw_redirect got v=%b ld=%b addr=%h exp v=0 ld=1 addr=00040", instr_valid, rom_load, rom_address);
        end
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (instr_valid) begin
                found = 1'b1;
                checks++;
                if ({pc, instruction} !== {20'h00040, rom_fn(20'h00040)}) begin
                    errors++;
                    $display("FAIL bw_word got pc=%h ins=%h exp pc=00040 ins=%h", pc, instruction, rom_fn(20'h00040));
                end
            end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL bw_timeout got=no word exp=word at 00040"); end
        leaked = leaked;
    endtask

    // Address wrap at the top of the space.
    task automatic test_wrap();
        bit found;
        found = 1'b0;
        do_reset();
        pc_write = 1'b1; instr_ready = 1'b1;
        branch = 1'b1; branch_target = 20'hFFFFF;
        tick();
        branch = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (instr_valid) begin
                found = 1'b1;
                checks++;
                if ({pc, instruction} !== {20'hFFFFF, rom_fn(20'hFFFFF)}) begin
                    errors++;
                    $display("FAIL wrap_word got pc=%h ins=%h exp pc=fffff ins=%h", pc, instruction, rom_fn(20'hFFFFF));
                end
            end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_timeout got=no word exp=word at fffff"); return; end
        #1;
        checks++;
        if ({rom_load, rom_address} !== {1'b1, 20'h00000}) begin
            errors++; $display("FAIL wrap_next got ld=%b addr=%h exp ld=1 addr=00000", rom_load, rom_address);
        end
    endtask

    // HALT word at ROM[3].
    task automatic test_halt();
        bit found;
        found = 1'b0;
        do_reset();
        pc_write = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 30 && !found; c++) begin
            #1;
            if (instr_valid && pc == 20'h3) begin
                found = 1'b1;
                checks++;
                if (instruction !== 20'hFFFFF) begin errors++; $display("FAIL halt_word got=%h exp=fffff", instruction); end
            end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL halt_timeout got=no word exp=word at 00003"); return; end
        #1;
`ifdef FETCH_HALT_EN
        checks++;
        if ({halted, instr_valid} !== 2'b10) begin
            errors++; $display("FAIL halt_enter got h=%b v=%b exp h=1 v=0", halted, instr_valid);
        end
        branch = 1'b1; branch_target = 20'h00040;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({halted, instr_valid, rom_load} !== 3'b100) begin
                errors++;
                $display("FAIL halt_stay cyc=%0d got h=%b v=%b ld=%b exp h=1 v=0 ld=0", c, halted, instr_valid, rom_load);
            end
            tick();
        end
        branch = 1'b0;
        do_reset();
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset got=%b exp=0", halted); end
`else
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (instr_valid) begin
                found = 1'b1;
                checks++;
                if ({pc, instruction, halted} !== {20'h4, rom_fn(20'h4), 1'b0}) begin
                    errors++;
                    $display("FAIL nohalt_next got pc=%h ins=%h h=%b exp pc=00004 ins=%h h=0",
                             pc, instruction, halted, rom_fn(20'h4));
                end
            end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL nohalt_timeout got=no word exp=word at 00004"); end
`endif
    endtask

    // Reset while a word is held.
    task automatic test_reset_hold();
        bit found;
        found = 1'b0;
        do_reset();
        pc_write = 1'b1; instr_ready = 1'b0;
        branch = 1'b1; branch_target = 20'h00123;
        tick();
        branch = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (instr_valid) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found || pc !== 20'h00123) begin
            errors++; $display("FAIL rh_hold got found=%0d pc=%h exp found=1 pc=00123", found, pc);
            return;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({instr_valid, pc, rom_load, rom_address} !== {1'b0, 20'h0, 1'b1, 20'h0}) begin
            errors++;
            $display("FAIL rh_after got v=%b pc=%h ld=%b addr=%h exp v=0 pc=00000 ld=1 addr=00000",
                     instr_valid, pc, rom_load, rom_address);
        end
    endtask

    // Randomized run against a program-order model.
    task automatic test_random();
        logic [19:0] want;
        logic [19:0] prev_pc;
        logic [19:0] prev_ins;
        bit prev_hold;
        int transfers;
        want = 20'h0; prev_hold = 1'b0; prev_pc = '0; prev_ins = '0; transfers = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pc_write      = ($urandom_range(0, 3) != 0);
            instr_ready   = ($urandom_range(0, 9) < 6);
            branch        = (c == 0) || ($urandom_range(0, 11) == 0);
            branch_target = 20'($urandom_range(32'h100, 32'hFFF00));
            #1;
            if (prev_hold) begin
                checks++;
                if ({instr_valid, pc, instruction} !== {1'b1, prev_pc, prev_ins}) begin
                    errors++;
                    $display("FAIL rnd_stable cyc=%0d got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                             c, instr_valid, pc, instruction, prev_pc, prev_ins);
                end
            end
            if (rom_load) begin
                checks++;
                if (rom_address !== want || branch || !pc_write || instr_valid) begin
                    errors++;
                    $display("FAIL rnd_read cyc=%0d got addr=%h br=%b pw=%b v=%b exp addr=%h br=0 pw=1 v=0",
                             c, rom_address, branch, pc_write, instr_valid, want);
                end
            end
            if (instr_valid && instr_ready && !branch) begin
                checks++;
                if ({pc, instruction} !== {want, rom_fn(want)}) begin
                    errors++;
                    $display("FAIL rnd_word cyc=%0d got pc=%h ins=%h exp pc=%h ins=%h",
                             c, pc, instruction, want, rom_fn(want));
                end
                want = want + 20'h1;
                transfers++;
            end
            prev_hold = instr_valid && !instr_ready && !branch;
            prev_pc   = pc;
            prev_ins  = instruction;
            if (branch) want = branch_target;
            tick();
        end
        branch = 1'b0;
        checks++;
        if (transfers < 20) begin errors++; $display("FAIL rnd_progress got=%0d exp>=20", transfers); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_wait();
        test_wrap();
        test_halt();
        test_reset_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
